av_copy_master: RTL

//  Avalon-MM master DMA engine: copies LEN 32-bit words from a source word address to a

---
 rtl/av_copy_master_pkg.sv | 21 ++
 rtl/av_copy_master.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/av_copy_master_pkg.sv
// Shared bus constants, state encoding and address helper for the Avalon-MM copy master.
package av_copy_master_pkg;

  localparam int unsigned AV_ADDR_W = 30;
  localparam int unsigned AV_DATA_W = 32;
  localparam logic [3:0]  AV_BE_ALL = 4'hF;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRdReq  = 3'd1,
    StRdWait = 3'd2,
    StWrReq  = 3'd3,
    StDone   = 3'd4
  } state_e;

  // Word addresses wrap silently at 2^AV_ADDR_W.
  function automatic logic [AV_ADDR_W-1:0] addr_inc(input logic [AV_ADDR_W-1:0] a);
    return a + 1'b1;
  endfunction

endpackage

// File: rtl/av_copy_master.sv
// Avalon-MM master copy engine: read one word, write it, repeat, with a single transaction
// outstanding. All bus outputs are registered.
module av_copy_master
  import av_copy_master_pkg::*;
#(
  parameter int unsigned LEN_BITS     = 16,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic                 i_Start,
  input  logic [AV_ADDR_W-1:0] i_SrcAddr,
  input  logic [AV_ADDR_W-1:0] i_DstAddr,
  input  logic [LEN_BITS-1:0]  i_Len,
  output logic                 o_Busy,
  output logic                 o_Done,
  output logic [AV_ADDR_W-1:0] o_AV_Addr,
  output logic [3:0]           o_AV_ByteEn,
  output logic                 o_AV_Read,
  output logic                 o_AV_Write,
  input  logic [AV_DATA_W-1:0] i_AV_ReadData,
  output logic [AV_DATA_W-1:0] o_AV_WriteData,
  input  logic                 i_AV_WaitRequest
);

  localparam int unsigned     LAT_W    = $clog2(READ_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);

  state_e                 r_State;
  logic [AV_ADDR_W-1:0]   r_Src;
  logic [AV_ADDR_W-1:0]   r_Dst;
  logic [LEN_BITS-1:0]    r_Remain;
  logic [LAT_W-1:0]       r_LatCnt;
  logic [AV_DATA_W-1:0]   r_Data;
  logic                   r_Busy;
  logic                   r_Done;
  logic [AV_ADDR_W-1:0]   r_Addr;
  logic [3:0]             r_ByteEn;
  logic                   r_Read;
  logic                   r_Write;

  logic w_Accept;
  logic w_LastWord;

  assign w_Accept   = ~i_AV_WaitRequest;
  assign w_LastWord = (r_Remain == LEN_BITS'(1));

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_State  <= StIdle;
      r_Src    <= '0;
      r_Dst    <= '0;
      r_Remain <= '0;
      r_LatCnt <= '0;
      r_Data   <= '0;
      r_Busy   <= 1'b0;
      r_Done   <= 1'b0;
      r_Addr   <= '0;
      r_ByteEn <= '0;
      r_Read   <= 1'b0;
      r_Write  <= 1'b0;
    end else begin
      r_Done <= 1'b0;
      unique case (r_State)
        StIdle: begin
          r_Busy <= 1'b0;
          if (i_Start) begin
            r_Busy <= 1'b1;
            if (i_Len != '0) begin
              r_Src    <= i_SrcAddr;
              r_Dst    <= i_DstAddr;
              r_Remain <= i_Len;
              r_Read   <= 1'b1;
              r_Addr   <= i_SrcAddr;
              r_ByteEn <= AV_BE_ALL;
              r_State  <= StRdReq;
            end else begin
              r_Done  <= 1'b1;
              r_State <= StDone;
            end
          end
        end

        // Strobe, address and byte enables simply hold while the slave stalls.
        StRdReq: begin
          if (w_Accept) begin
            r_Read   <= 1'b0;
            r_Addr   <= '0;
            r_ByteEn <= '0;
            r_LatCnt <= LAT_LOAD;
            r_State  <= StRdWait;
          end
        end

        StRdWait: begin
          if (r_LatCnt == '0) begin
            r_Data   <= i_AV_ReadData;
            r_Write  <= 1'b1;
            r_Addr   <= r_Dst;
            r_ByteEn <= AV_BE_ALL;
            r_State  <= StWrReq;
          end else begin
            r_LatCnt <= r_LatCnt - 1'b1;
          end
        end

        StWrReq: begin
          if (w_Accept) begin
            r_Write  <= 1'b0;
            r_Src    <= addr_inc(r_Src);
            r_Dst    <= addr_inc(r_Dst);
            r_Remain <= r_Remain - 1'b1;
            if (w_LastWord) begin
              r_Addr   <= '0;
              r_ByteEn <= '0;
              r_Done   <= 1'b1;
              r_State  <= StDone;
            end else begin
              r_Read   <= 1'b1;
              r_Addr   <= addr_inc(r_Src);
              r_ByteEn <= AV_BE_ALL;
              r_State  <= StRdReq;
            end
          end
        end

        StDone: begin
          r_Busy  <= 1'b0;
          r_State <= StIdle;
        end

        default: begin
          r_State <= StIdle;
        end
      endcase
    end
  end

  assign o_Busy         = r_Busy;
  assign o_Done         = r_Done;
  assign o_AV_Addr      = r_Addr;
  assign o_AV_ByteEn    = r_ByteEn;
  assign o_AV_Read      = r_Read;
  assign o_AV_Write     = r_Write;
  assign o_AV_WriteData = r_Data;

endmodule
